// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one W-bit AND/NAND/OR/NOR unit between two requesters.
// Optional build macro LOGIC_OP_XOR_EN makes XOR (100) and XNOR (101) legal opcodes.
module logic_op_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [2:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [2:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         err,
  output logic         busy
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            port_q, port_d;
  logic            last_q, last_d;

  logic            gnt0_d, gnt1_d, done0_d, done1_d, err_d, busy_d;
  logic [W-1:0]    result_d;

  logic            winner_c;
  logic [W-1:0]    alu_c;
  logic            illegal_c;

  // Bitwise logic unit on the captured operands; illegal codes yield zero.
  always_comb begin
    alu_c     = '0;
    illegal_c = 1'b0;
    case (op_q)
      3'b000:  alu_c = a_q | b_q;
      3'b001:  alu_c = ~(a_q | b_q);
      3'b010:  alu_c = a_q & b_q;
      3'b011:  alu_c = ~(a_q & b_q);
`ifdef LOGIC_OP_XOR_EN
      3'b100:  alu_c = a_q ^ b_q;
      3'b101:  alu_c = ~(a_q ^ b_q);
`endif
      default: illegal_c = 1'b1;
    endcase
  end

  // A lone requester wins; on contention the port not served last wins.
  assign winner_c = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    port_d   = port_q;
    last_d   = last_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = 1'b0;
    result_d = result;
    busy_d   = busy;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          port_d  = winner_c;
          op_d    = winner_c ? op1 : op0;
          a_d     = winner_c ? a1  : a0;
          b_d     = winner_c ? b1  : b0;
          gnt0_d  = ~winner_c;
          gnt1_d  = winner_c;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = illegal_c ? '0 : alu_c;
        err_d    = illegal_c;
        done0_d  = ~port_q;
        done1_d  = port_q;
        last_d   = port_q;
        state_d  = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // last_q resets to port 1 so port 0 holds first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      port_q  <= port_d;
      last_q  <= last_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      done0   <= done0_d;
      done1   <= done1_d;
      err     <= err_d;
      result  <= result_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one W-bit AND/NAND/OR/NOR logic unit between two requesters (port 0, port 1).
- A 3-state FSM with round-robin priority grants one requester, captures its operands and opcode, computes one registered result, and signals completion.
- Sits between operand sources and the logic-unit datapath of the logic-gate exercises. It sequences that unit and replaces per-source static select wiring.

Parameters:
- W, 4, operand/result width in bits (min 1)

Ports:
- clk     input   1  single clock, all state on rising edge
- rst_n   input   1  synchronous, active-low reset
- req0    input   1  port 0 request; held until gnt0 seen
- op0     input   3  port 0 opcode
- a0      input   W  port 0 operand A
- b0      input   W  port 0 operand B
- req1    input   1  port 1 request
- op1     input   3  port 1 opcode
- a1      input   W  port 1 operand A
- b1      input   W  port 1 operand B
- gnt0    output  1  1-cycle pulse: port 0 operands captured
- gnt1    output  1  1-cycle pulse: port 1 operands captured
- done0   output  1  1-cycle pulse: result valid for port 0
- done1   output  1  1-cycle pulse: result valid for port 1
- result  output  W  shared registered result
- err     output  1  illegal opcode flag, valid with done
- busy    output  1  high when FSM not IDLE

Behaviour:
- Reset (rst_n=0 at an edge) drives these values:
  - state=IDLE
  - gnt0/gnt1/done0/done1/err/busy=0
  - result=0
  - last_grant=1, so port 0 has first priority
- Opcode map, bitwise over W:
  - op[1] selects group: 1=AND family, 0=OR family
  - op[0] inverts the output
  - 000 OR, 001 NOR, 010 AND, 011 NAND
  - op[2]=1 is illegal in the base build
- IDLE:
  - No request: nothing happens.
  - Any req: choose a winner.
    - Only one req high: that port wins.
    - Both high: the port != last_grant wins.
  - At the edge:
    - capture winner's op/a/b into internal regs
    - gntX<=1
    - busy<=1
    - ->EXEC
- EXEC, one cycle:
  - result<=f(op,a,b)
  - doneX<=1 for the captured port
  - err<=(op illegal)
  - last_grant<=X
  - gnt<=0
  - ->RESP
- Illegal opcode: result<=0, err<=1.
- RESP, one cycle:
  - doneX<=0, err<=0, busy<=0
  - ->IDLE
- Timing:
  - Latency: req sampled at edge k, gnt high k..k+1, done/result high k+1..k+2.
  - Next grant at earliest edge k+3, so throughput is 1 op per 3 cycles.
- Requester contract:
  - Keep req/op/a/b stable until gnt is seen.
  - Deassert req before edge k+2, or a new transaction starts.
  - Operand changes after capture have no effect.
- result holds its value between done pulses. Only EXEC or reset changes it.
- gnt0&gnt1, done0&done1 and gntX&doneX are never high together.
- Reset mid-operation (in EXEC or RESP): the transaction is dropped, no done is issued, and all outputs return to reset values on that edge.
- A request arriving while busy is not lost. It waits at IDLE and is granted per priority.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1.

Optional Feature:
- LOGIC_OP_XOR_EN
  - Defined: op 100=XOR and 101=XNOR are legal and produce bitwise results with err=0. Codes 11x are still illegal.
  - Undefined: all op[2]=1 codes are illegal (result 0, err=1).
- Port widths are identical in both builds.

Test Plan:
- Reset, then req0=1, op0=010, a0=4'b1100, b0=4'b1010:
  - gnt0 at edge 1
  - done0=1, result=4'b1000, err=0 at edge 2
  - busy=0 at edge 3
- req1 only, op1=001 (NOR), a1=4'b0011, b1=4'b0101: done1 with result=4'b1000.
- req0 and req1 both held high for 12 cycles from reset: gnt order 0,1,0,1; one grant every 3 cycles; never simultaneous.
- op0=110, and op0=100 in the base build:
  - both give result=0, err=1 with done0
  - with LOGIC_OP_XOR_EN, op0=100 on 1100/1010 gives 0110, err=0
- rst_n=0 during EXEC of a port-1 op: no done1 ever pulses; result=0; next req0 is granted first.
- Operands changed the cycle after gnt0 (a0 1111->0000, op0=011 NAND, original a0=1111, b0=1111): result=4'b0000 from the captured values.
